// File: rtl/wb_drain_ctrl.sv
// Drains the uncached-store write buffer onto the SRAM-like bus ahead of uncached loads; req rises 1 cycle after work appears.
// Holds req until addr_ok with one FIFO pop per accepted store; `WB_PERF_CNT_EN adds store/load-stall counters (else tied 0).
module wb_drain_ctrl #(
    parameter int ENTRY_W = 68
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [ENTRY_W-1:0] fifo_dout,
    output logic               fifo_rd_en,
    input  logic               rd_req,
    input  logic [31:0]        rd_addr,
    input  logic [1:0]         rd_size,
    output logic               rd_addr_ok,
    output logic               rd_data_ok,
    output logic [31:0]        rd_rdata,
    output logic               req,
    output logic               wr,
    output logic [1:0]         size,
    output logic [31:0]        addr,
    output logic [3:0]         wstrb,
    output logic [31:0]        wdata,
    input  logic               addr_ok,
    input  logic               data_ok,
    input  logic [31:0]        rdata,
    output logic               wb_idle,
    output logic [31:0]        perf_wr_cnt,
    output logic [31:0]        perf_rd_stall_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_DATA = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    state_t      arb_state;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_take;
    logic [3:0]  head_wstrb;
    logic [31:0] head_addr;
    logic [31:0] head_data;

    assign head_wstrb = fifo_dout[67:64];
    assign head_addr  = fifo_dout[63:32];
    assign head_data  = fifo_dout[31:0];

    // Non-contiguous or empty strobe patterns fall back to a full word transfer.
    function automatic logic [1:0] strb_size(input logic [3:0] s);
        case (s)
            4'b1111:                             return 2'd2;
            4'b0011, 4'b1100:                    return 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000:  return 2'd0;
            default:                             return 2'd2;
        endcase
    endfunction

    // Stores always win; a waiting load only goes once the buffer is empty.
    always_comb begin
        arb_state = IDLE;
        if (!fifo_empty) begin
            arb_state = W_ADDR;
        end else if (rd_req) begin
            arb_state = R_ADDR;
        end
    end

    always_comb begin
        state_nxt  = state;
        req        = 1'b0;
        wr         = 1'b0;
        size       = 2'd0;
        addr       = 32'd0;
        wstrb      = 4'd0;
        wdata      = 32'd0;
        fifo_rd_en = 1'b0;
        rd_addr_ok = 1'b0;
        rd_data_ok = 1'b0;
        rd_rdata   = 32'd0;
        case (state)
            IDLE: begin
                state_nxt = arb_state;
            end
            W_ADDR: begin
                req   = 1'b1;
                wr    = 1'b1;
                size  = strb_size(head_wstrb);
                addr  = head_addr;
                wstrb = head_wstrb;
                wdata = head_data;
                if (addr_ok) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = W_DATA;
                end
            end
            W_DATA: begin
                if (data_ok) begin
                    state_nxt = arb_state;
                end
            end
            R_ADDR: begin
                req  = 1'b1;
                size = ld_size;
                addr = ld_addr;
                if (addr_ok) begin
                    rd_addr_ok = 1'b1;
                    state_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (data_ok) begin
                    rd_data_ok = 1'b1;
                    rd_rdata   = rdata;
                    state_nxt  = arb_state;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ld_take = (state != R_ADDR) && (state_nxt == R_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ld_addr <= 32'd0;
            ld_size <= 2'd0;
        end else begin
            state <= state_nxt;
            if (ld_take) begin
                ld_addr <= rd_addr;
                ld_size <= rd_size;
            end
        end
    end

    assign wb_idle = (state == IDLE) && fifo_empty;

`ifdef WB_PERF_CNT_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        rd_stall;

    // A load is stalled whenever it is waiting behind a queued or in-flight store.
    assign rd_stall = rd_req
                   && (state == IDLE || state == W_ADDR || state == W_DATA)
                   && (!fifo_empty || state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q    <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (fifo_rd_en) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (rd_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_wr_cnt       = wr_cnt_q;
    assign perf_rd_stall_cnt = stall_cnt_q;
`else
    assign perf_wr_cnt       = 32'd0;
    assign perf_rd_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Bench for wb_drain_ctrl: a transaction-level model (pending issue / outstanding response) checked every cycle,
// directed scenarios pinned with literal values, then randomized FIFO pushes, loads and bus handshakes.
module tb_wb_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [67:0] fifo_dout;
    logic        fifo_rd_en;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_addr_ok;
    logic        rd_data_ok;
    logic [31:0] rd_rdata;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        wb_idle;
    logic [31:0] perf_wr_cnt;
    logic [31:0] perf_rd_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [67:0] wq[$];
    logic        outst;

    // values seen at the falling edge, used by the environment after the next rising edge
    logic smp_pop, smp_rao, smp_req, smp_aok, smp_dok;

    // model: one transaction waiting for its address phase, one waiting for its response
    logic        m_iss, m_iss_wr, m_out, m_out_wr;
    logic [31:0] m_ld_addr;
    logic [1:0]  m_ld_size;
    logic [31:0] m_wr_cnt, m_stall;
    logic        e_req, e_wr, e_pop, e_rao, e_rdo, e_idle, e_stall;
    logic [31:0] e_addr, e_wdata, e_pw, e_ps;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;

    logic [7:0]  reqs, raos, rdos;
    int          pops;
    int          k;

    wb_drain_ctrl #(.ENTRY_W(68)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty        (fifo_empty),
        .fifo_dout         (fifo_dout),
        .fifo_rd_en        (fifo_rd_en),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_size           (rd_size),
        .rd_addr_ok        (rd_addr_ok),
        .rd_data_ok        (rd_data_ok),
        .rd_rdata          (rd_rdata),
        .req               (req),
        .wr                (wr),
        .size              (size),
        .addr              (addr),
        .wstrb             (wstrb),
        .wdata             (wdata),
        .addr_ok           (addr_ok),
        .data_ok           (data_ok),
        .rdata             (rdata),
        .wb_idle           (wb_idle),
        .perf_wr_cnt       (perf_wr_cnt),
        .perf_rd_stall_cnt (perf_rd_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endfunction

    function automatic logic [1:0] exp_size(input logic [3:0] s);
        if ($countones(s) == 4) return 2'd2;
        if (s == 4'b0011 || s == 4'b1100) return 2'd1;
        if ($countones(s) == 1) return 2'd0;
        return 2'd2;
    endfunction

    function automatic void fifo_drive();
        fifo_empty = (wq.size() == 0);
        fifo_dout  = fifo_empty ? 68'h0 : wq[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (smp_pop && wq.size() > 0) void'(wq.pop_front());
        if (smp_rao) rd_req = 1'b0;
        if (smp_dok && outst) outst = 1'b0;
        if (smp_req && smp_aok) outst = 1'b1;
        fifo_drive();
    endtask

    // compare process: expectations come from the model state plus the current inputs
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_iss = 0; m_iss_wr = 0; m_out = 0; m_out_wr = 0;
                m_ld_addr = 0; m_ld_size = 0; m_wr_cnt = 0; m_stall = 0;
            end
            e_req = m_iss; e_wr = m_iss && m_iss_wr;
            e_pop = 0; e_rao = 0; e_addr = 0; e_size = 0; e_wstrb = 0; e_wdata = 0;
            if (m_iss && m_iss_wr) begin
                e_addr  = fifo_dout[63:32];
                e_wdata = fifo_dout[31:0];
                e_wstrb = fifo_dout[67:64];
                e_size  = exp_size(e_wstrb);
                e_pop   = addr_ok;
            end else if (m_iss) begin
                e_addr = m_ld_addr;
                e_size = m_ld_size;
                e_rao  = addr_ok;
            end
            e_rdo  = m_out && !m_out_wr && data_ok;
            e_idle = !m_iss && !m_out && fifo_empty;
            e_stall = rd_req && !(m_iss && !m_iss_wr) && !(m_out && !m_out_wr)
                      && (!fifo_empty || (m_iss && m_iss_wr) || (m_out && m_out_wr));
`ifdef WB_PERF_CNT_EN
            e_pw = m_wr_cnt; e_ps = m_stall;
`else
            e_pw = 0; e_ps = 0;
`endif
            chk1("req", req, e_req);
            chk1("wr", wr, e_wr);
            chk1("fifo_rd_en", fifo_rd_en, e_pop);
            chk1("rd_addr_ok", rd_addr_ok, e_rao);
            chk1("rd_data_ok", rd_data_ok, e_rdo);
            chk1("wb_idle", wb_idle, e_idle);
            chk32("perf_wr_cnt", perf_wr_cnt, e_pw);
            chk32("perf_rd_stall_cnt", perf_rd_stall_cnt, e_ps);
            if (e_req) begin
                chk32("addr", addr, e_addr);
                chk32("size", {30'd0, size}, {30'd0, e_size});
                chk32("wstrb", {28'd0, wstrb}, {28'd0, e_wstrb});
            end
            if (e_wr) chk32("wdata", wdata, e_wdata);
            if (e_rdo) chk32("rd_rdata", rd_rdata, rdata);
            if (reset) begin
                chk32("rst_addr", addr, 32'd0);
                chk32("rst_wdata", wdata, 32'd0);
                chk32("rst_rd_rdata", rd_rdata, 32'd0);
                chk32("rst_size_wstrb", {26'd0, size, wstrb}, 32'd0);
            end
            smp_pop = fifo_rd_en; smp_rao = rd_addr_ok; smp_req = req;
            smp_aok = addr_ok; smp_dok = data_ok;
            if (!reset) begin
                if (e_pop) m_wr_cnt = m_wr_cnt + 1;
                if (e_stall) m_stall = m_stall + 1;
                if (m_iss && addr_ok) begin
                    m_out = 1; m_out_wr = m_iss_wr; m_iss = 0;
                end else if (!m_iss && (!m_out || data_ok)) begin
                    m_out = 0;
                    if (!fifo_empty) begin
                        m_iss = 1; m_iss_wr = 1;
                    end else if (rd_req) begin
                        m_iss = 1; m_iss_wr = 0; m_ld_addr = rd_addr; m_ld_size = rd_size;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1; rd_req = 0; rd_addr = 0; rd_size = 0;
        addr_ok = 0; data_ok = 0; rdata = 0; outst = 0;
        smp_pop = 0; smp_rao = 0; smp_req = 0; smp_aok = 0; smp_dok = 0;
        fifo_drive();
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_req", req, 1'b0);
        chk1("reset_wb_idle", wb_idle, 1'b1);
        reset = 0;

        // single half-word store, data_ok two cycles after addr_ok
        tick();
        wq.push_back({4'b0011, 32'h1FAF_0010, 32'h0000_ABCD});
        fifo_drive();
        addr_ok = 1; data_ok = 0;
        tick(); #1;
        chk1("t_single_req", req, 1'b1);
        chk1("t_single_wr", wr, 1'b1);
        chk32("t_single_size", {30'd0, size}, 32'd1);
        chk32("t_single_addr", addr, 32'h1FAF_0010);
        chk32("t_single_wstrb", {28'd0, wstrb}, 32'h3);
        chk32("t_single_wdata", wdata, 32'h0000_ABCD);
        chk1("t_single_pop", fifo_rd_en, 1'b1);
        tick(); addr_ok = 0; #1;
        chk1("t_single_req_drop", req, 1'b0);
        chk1("t_single_busy", wb_idle, 1'b0);
        tick(); data_ok = 1; #1;
        chk1("t_single_busy2", wb_idle, 1'b0);
        tick(); data_ok = 0; #1;
        chk1("t_single_idle", wb_idle, 1'b1);

        // three back-to-back stores with single-cycle handshakes
        tick();
        wq.push_back({4'b1111, 32'h0000_1000, 32'h1111_1111});
        wq.push_back({4'b0100, 32'h0000_2000, 32'h2222_2222});
        wq.push_back({4'b1010, 32'h0000_3000, 32'h3333_3333});
        fifo_drive();
        addr_ok = 1; data_ok = 1;
        reqs = 0; pops = 0;
        for (int i = 1; i <= 7; i++) begin
            tick(); #1;
            reqs[i] = req;
            if (fifo_rd_en) pops++;
        end
        chk32("t_b2b_req_pattern", {24'd0, reqs}, 32'h2A);
        chk32("t_b2b_pops", pops, 32'd3);
        chk1("t_b2b_idle", wb_idle, 1'b1);

        // load waits behind two pending stores
        tick();
        wq.push_back({4'b0001, 32'h0000_4000, 32'h4444_4444});
        wq.push_back({4'b1100, 32'h0000_5000, 32'h5555_5555});
        fifo_drive();
        rd_req = 1; rd_addr = 32'h1FD0_F000; rd_size = 2;
        addr_ok = 1; data_ok = 1; rdata = 32'h1234_5678;
        raos = 0; rdos = 0;
        for (int i = 1; i <= 7; i++) begin
            tick(); #1;
            raos[i] = rd_addr_ok;
            rdos[i] = rd_data_ok;
            if (i == 5) begin
                chk32("t_order_addr", addr, 32'h1FD0_F000);
                chk32("t_order_size", {30'd0, size}, 32'd2);
                chk1("t_order_wr", wr, 1'b0);
            end
            if (i == 6) chk32("t_order_rdata", rd_rdata, 32'h1234_5678);
        end
        chk32("t_order_rao", {24'd0, raos}, 32'h20);
        chk32("t_order_rdo", {24'd0, rdos}, 32'h40);

        // load on an empty buffer, addr_ok held off for three cycles
        tick();
        rd_req = 1; rd_addr = 32'h1FC0_0004; rd_size = 0;
        addr_ok = 0; data_ok = 0; rdata = 32'hCAFE_F00D;
        reqs = 0; raos = 0; rdos = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            addr_ok = (i == 4);
            data_ok = (i == 6);
            #1;
            reqs[i] = req; raos[i] = rd_addr_ok; rdos[i] = rd_data_ok;
        end
        chk32("t_wait_req", {24'd0, reqs}, 32'h1E);
        chk32("t_wait_rao", {24'd0, raos}, 32'h10);
        chk32("t_wait_rdo", {24'd0, rdos}, 32'h40);

        // asynchronous reset in the middle of a store address phase
        tick();
        wq.push_back({4'b1111, 32'h0000_6000, 32'h6666_6666});
        fifo_drive();
        addr_ok = 0; data_ok = 0;
        tick(); #1;
        chk1("t_arst_req_before", req, 1'b1);
        addr_ok = 1;
        #1;
        chk1("t_arst_pop_before", fifo_rd_en, 1'b1);
        reset = 1;
        #1;
        chk1("t_arst_req", req, 1'b0);
        chk1("t_arst_pop", fifo_rd_en, 1'b0);
        chk1("t_arst_idle_follows", wb_idle, 1'b0);
        wq.delete();
        fifo_drive();
        addr_ok = 0; outst = 0;
        tick();
        tick();
        reset = 0;
        tick(); #1;
        chk1("t_arst_back_idle", wb_idle, 1'b1);

        // five stores with a load arriving mid-drain, stalled seven cycles
        tick();
        for (int i = 0; i < 5; i++) wq.push_back({4'b1111, 32'h0000_7000 + 32'(i * 4), 32'(i)});
        fifo_drive();
        addr_ok = 1; data_ok = 1; rdata = 32'h0BAD_BEEF;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 4) begin
                rd_req = 1; rd_addr = 32'h1FD0_0100; rd_size = 1;
            end
            #1;
            if (i == 11) chk1("t_perf_rao", rd_addr_ok, 1'b1);
        end
`ifdef WB_PERF_CNT_EN
        chk32("t_perf_wr", perf_wr_cnt, 32'd5);
        chk32("t_perf_stall", perf_rd_stall_cnt, 32'd7);
`else
        chk32("t_perf_wr", perf_wr_cnt, 32'd0);
        chk32("t_perf_stall", perf_rd_stall_cnt, 32'd0);
`endif

        // randomized traffic with sparse and dense store phases
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (wq.size() < 32 && ($urandom % (((cyc / 500) % 2 == 1) ? 2 : 7)) == 0) begin
                wq.push_back({4'($urandom), $urandom, $urandom});
                fifo_drive();
            end
            if (!rd_req && ($urandom % 6) == 0) begin
                rd_req  = 1;
                rd_addr = $urandom;
                rd_size = 2'($urandom % 3);
            end
            addr_ok = ($urandom % 3) != 0;
            data_ok = outst ? (($urandom % 2) == 1) : (($urandom % 16) == 0);
            rdata   = $urandom;
        end

        k = 0;
        do begin
            tick();
            addr_ok = 1;
            data_ok = outst;
            rdata   = $urandom;
            #1;
            k++;
        end while (!(wb_idle && !rd_req && wq.size() == 0) && k < 300);
        chk1("drain_done", wb_idle && !rd_req, 1'b1);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_drain_ctrl.md
# wb_drain_ctrl

- Drains the uncached-store write buffer onto the CPU's SRAM-like bus. The write buffer is a 68-bit, 32-deep FIFO.
- Arbitrates the bus between buffered writes and uncached loads, with strict store-before-load ordering.
- Sits between the write-buffer FIFO and the bus bridge.
- Provides `wb_idle` to the pipeline for `sync` and cache-op fencing.

## Interface
Parameters:
- `ENTRY_W`, default 68: FIFO entry width. Layout is `{wstrb[67:64], addr[63:32], data[31:0]}`.

Ports:
- `clk`  in  1  — the single clock.
- `reset`  in  1  — asynchronous, active-high.
- `fifo_empty`  in  1  — write-buffer FIFO empty flag.
- `fifo_dout`  in  68  — FIFO head entry, read asynchronously.
- `fifo_rd_en`  out  1  — pops the FIFO head; one-cycle pulse.
- `rd_req`  in  1  — uncached load request. Held high until `rd_addr_ok`.
- `rd_addr`  in  32  — load address.
- `rd_size`  in  2  — load size: 0 = byte, 1 = half, 2 = word.
- `rd_addr_ok`  out  1  — load accepted by the bus; one-cycle pulse.
- `rd_data_ok`  out  1  — load data valid; one-cycle pulse.
- `rd_rdata`  out  32  — load data, valid with `rd_data_ok`.
- `req`, `wr`  out  1  — bus request and write flag.
- `size`  out  2  — bus transfer size.
- `addr`  out  32  — bus address.
- `wstrb`  out  4  — bus byte strobes.
- `wdata`  out  32  — bus write data.
- `addr_ok`  in  1  — bus address handshake.
- `data_ok`  in  1  — bus data or write-response handshake.
- `rdata`  in  32  — bus read data.
- `wb_idle`  out  1  — FIFO empty and no transaction in flight.
- `perf_wr_cnt`, `perf_rd_stall_cnt`  out  32  — performance counters; see Configuration.

## Operation
- FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA. Reset state is IDLE.
- Arbitration (writes strictly before loads). From IDLE, and from any state when its transaction ends:
  - `!fifo_empty` → W_ADDR;
  - else `rd_req` → R_ADDR, latching `rd_addr` and `rd_size`;
  - else → IDLE.
- W_ADDR:
  - Drives `req=1`, `wr=1`, `addr`/`wdata`/`wstrb` combinationally from `fifo_dout`.
  - `size` is derived from `wstrb`: 4'b1111 → 2; 4'b0011 or 4'b1100 → 1; one-hot → 0; any other pattern → 2.
  - On `addr_ok`: `fifo_rd_en=1` for that cycle, then → W_DATA.
- W_DATA:
  - `req=0`; waits for `data_ok`.
  - On `data_ok`: apply the arbitration rule. Back-to-back writes do not pass through IDLE.
- R_ADDR:
  - Drives `req=1`, `wr=0`, `wstrb=0`, with the latched address and size.
  - On `addr_ok`: `rd_addr_ok=1`, then → R_DATA.
- R_DATA:
  - On `data_ok`: `rd_data_ok=1` and `rd_rdata=rdata` in the same cycle, then apply the arbitration rule.
- A load is never issued while the FIFO is non-empty or a write is in W_DATA.
- A load arriving during a write drain waits. Stores pushed while a load waits overtake it; this is intended.
- `data_ok` seen in W_ADDR, R_ADDR or IDLE is a protocol violation and is ignored.
- `wb_idle = (state==IDLE) && fifo_empty`.

## Timing
- Reset is asynchronous: state goes to IDLE immediately.
- Values while `reset` is asserted: `req`, `wr`, `fifo_rd_en`, `rd_addr_ok`, `rd_data_ok` = 0; `size`, `addr`, `wstrb`, `wdata`, `rd_rdata` = 0; latched load fields = 0; counters = 0. `wb_idle` follows `fifo_empty`.
- Start-up latency: IDLE with `!fifo_empty` at cycle N gives `req=1` at cycle N+1. Same for `rd_req`.
- `addr_ok` in the same cycle as `req` completes the address phase; there is no minimum wait.
- `data_ok` is accepted no earlier than the cycle after `addr_ok`.
- `req` stays high, with address and data stable, until `addr_ok`.
- `fifo_rd_en` is asserted only in W_ADDR with `addr_ok`. This gives exactly one pop per issued write. The new head is visible the next cycle.
- Reset mid-transaction abandons it with no pop or pulse. The bus bridge is reset by the same `reset`.

## Configuration
- `WB_PERF_CNT_EN` defined:
  - `perf_wr_cnt` increments on each `fifo_rd_en`.
  - `perf_rd_stall_cnt` increments each cycle `rd_req` is high while state is IDLE, W_ADDR or W_DATA and a write is pending or in flight.
  - Both counters are 32 bits and wrap at 2^32.
- Not defined: both ports are tied to 0 and the counter logic is absent. The port list is unchanged.

## Test plan
- Reset asserted asynchronously mid-W_ADDR → `req=0`, `fifo_rd_en=0` the same cycle; state returns to IDLE.
- FIFO holds one entry `{4'b0011, 32'h1FAF_0010, 32'h0000_ABCD}`, `addr_ok` tied 1, `data_ok` two cycles later → bus shows `req=1 wr=1 size=1 addr=1FAF0010 wstrb=0011 wdata=ABCD` for one cycle; one `fifo_rd_en` pulse; `wb_idle=1` after `data_ok`.
- Three entries back-to-back, `addr_ok`/`data_ok` each 1 cycle → three pops; `req` reasserts in the `data_ok` cycle+1 with no IDLE cycle.
- `rd_req` at 0x1FD0_F000 size 2 while two writes are pending → load issued only after the second write's `data_ok`; `rd_data_ok` carries `rdata=32'h1234_5678`.
- `rd_req` with an empty FIFO and `addr_ok` delayed 3 cycles → `req` held 3 cycles, then one `rd_addr_ok` pulse, then `rd_data_ok`.
- With `WB_PERF_CNT_EN`: 5 writes with a load blocked for 7 cycles → `perf_wr_cnt=5`, `perf_rd_stall_cnt=7`. Without the macro both read 0.
